// File: rtl/wide_add_seq_pkg.sv
// rtl/wide_add_seq_pkg.sv - shared FSM states, default geometry and index-width helper
package wide_add_seq_pkg;

   localparam int DEF_SLICE_W    = 32;
   localparam int DEF_NUM_SLICES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// rtl/wide_add_seq_if.sv - operand/result handshake bundle; op_sub exists only with WIDE_ADD_SEQ_SUB_EN
interface wide_add_seq_if
   import wide_add_seq_pkg::*;
#(
   parameter int SLICE_W    = DEF_SLICE_W,
   parameter int NUM_SLICES = DEF_NUM_SLICES
);
   localparam int W = SLICE_W * NUM_SLICES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
   logic         op_sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] res;
   logic         res_cout;
   logic         busy;

   modport master (
`ifdef WIDE_ADD_SEQ_SUB_EN
      output op_sub,
`endif
      output in_valid, op_a, op_b, op_cin, out_ready,
      input  in_ready, out_valid, res, res_cout, busy
   );

   modport slave (
`ifdef WIDE_ADD_SEQ_SUB_EN
      input  op_sub,
`endif
      input  in_valid, op_a, op_b, op_cin, out_ready,
      output in_ready, out_valid, res, res_cout, busy
   );

endinterface

// File: rtl/wide_add_seq_add_slice.sv
// rtl/wide_add_seq_add_slice.sv - combinational W-bit adder slice with carry in/out
module add_slice #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - wide adder computed one slice per cycle through a single shared add_slice
// Optional subtract mode (A + ~B + 1) is built when WIDE_ADD_SEQ_SUB_EN is defined.
module wide_add_seq
   import wide_add_seq_pkg::*;
#(
   parameter int SLICE_W    = DEF_SLICE_W,
   parameter int NUM_SLICES = DEF_NUM_SLICES
) (
   input  logic         clk,
   input  logic         rst,
   wide_add_seq_if.slave bus
);

   localparam int W     = SLICE_W * NUM_SLICES;
   localparam int IDX_W = idx_width(NUM_SLICES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLICES - 1);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] RUN  = ST_RUN;
   localparam logic [1:0] DONE = ST_DONE;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     res_q, res_d;
   logic             res_cout_q, res_cout_d;

   logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
   logic               sl_cout;

   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int s = 0; s < NUM_SLICES; s++) begin
         if (idx_q == IDX_W'(s)) begin
            sl_a = a_q[s*SLICE_W +: SLICE_W];
            sl_b = b_q[s*SLICE_W +: SLICE_W];
         end
      end
   end

   add_slice #(.W(SLICE_W)) u_add (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .sum  (sl_sum),
      .cout (sl_cout)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      res_cout_d = res_cout_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               carry_d = bus.op_cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
               // Two's-complement subtract: invert B once, seed carry with 1
               if (bus.op_sub) begin
                  b_d     = ~bus.op_b;
                  carry_d = 1'b1;
               end
`endif
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int s = 0; s < NUM_SLICES; s++) begin
               if (idx_q == IDX_W'(s)) res_d[s*SLICE_W +: SLICE_W] = sl_sum;
            end
            carry_d = sl_cout;
            if (idx_q == IDX_LAST) begin
               res_cout_d = sl_cout;
               idx_d      = '0;
               state_d    = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         res_cout_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         res_cout_q <= res_cout_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.res       = res_q;
   assign bus.res_cout  = res_cout_q;

endmodule
